// File: rtl/rf_pkg.sv
// Shared types and constants for the register-bank writeback path.
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned NUM_REGS     = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0]    dest;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Execute/memory-side bundle for the writeback controller; master = producer stages, slave = controller.
interface regfile_writeback_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_dest;
    logic [XLEN-1:0]      alu_data;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [REG_IDX_W-1:0] ld_dest;
    logic [XLEN-1:0]      ld_data;
    logic                 ld_issue;
    logic [REG_IDX_W-1:0] ld_issue_dest;
    logic [NUM_REGS-1:0]  busy;
    logic                 we;
    logic [REG_IDX_W-1:0] dest;
    logic [XLEN-1:0]      rd;
    logic                 waw_err;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_valid, ld_dest, ld_data,
        output ld_issue, ld_issue_dest,
        input  ld_ready, busy, we, dest, rd, waw_err
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_valid, ld_dest, ld_data,
        input  ld_issue, ld_issue_dest,
        output ld_ready, busy, we, dest, rd, waw_err
    );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with wrap-around pointers and an occupancy counter.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Register-bank writeback: ALU-priority arbitration over a load-result queue, plus pending-load scoreboard.
// Optional sticky WAW hazard detection is built when WB_WAW_CHECK_EN is defined.
module regfile_writeback
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned LQ_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    regfile_writeback_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    // Local mirror of wb_entry_t so the queue follows the XLEN parameter.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [XLEN-1:0]      data;
    } lq_entry_t;

    lq_entry_t            w_push_entry;
    lq_entry_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_sel_valid;
    logic [REG_IDX_W-1:0] w_sel_dest;
    logic [XLEN-1:0]      w_sel_data;
    logic                 w_sel_live;
    logic [NUM_REGS-1:0]  w_busy_next;

    logic                 r_we;
    logic [REG_IDX_W-1:0] r_dest;
    logic [XLEN-1:0]      r_rd;
    logic [NUM_REGS-1:0]  r_busy;

    assign w_push_entry = '{dest: bus.ld_dest, data: bus.ld_data};
    assign w_push       = bus.ld_valid && !w_full;
    assign w_pop        = !bus.alu_valid && !w_empty;
    assign bus.ld_ready = (w_count != CNT_W'(LQ_DEPTH));

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH ($bits(lq_entry_t))
    ) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_sel_valid = bus.alu_valid || !w_empty;
        w_sel_dest  = bus.alu_valid ? bus.alu_dest : w_head.dest;
        w_sel_data  = bus.alu_valid ? bus.alu_data : w_head.data;
        w_sel_live  = w_sel_valid && (w_sel_dest != '0);
    end

    // Issue set is applied after pop clear so a same-index collision leaves the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head.dest] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_dest != '0)) begin
            w_busy_next[bus.ld_issue_dest] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_dest <= '0;
            r_rd   <= '0;
            r_busy <= '0;
        end else begin
            r_we   <= w_sel_live;
            r_dest <= w_sel_live ? w_sel_dest : '0;
            r_rd   <= w_sel_live ? w_sel_data : '0;
            r_busy <= w_busy_next;
        end
    end

    assign bus.we   = r_we;
    assign bus.dest = r_dest;
    assign bus.rd   = r_rd;
    assign bus.busy = r_busy;

`ifdef WB_WAW_CHECK_EN
    logic r_waw_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waw_err <= 1'b0;
        end else if (bus.alu_valid && (bus.alu_dest != '0) && r_busy[bus.alu_dest]) begin
            r_waw_err <= 1'b1;
        end
    end

    assign bus.waw_err = r_waw_err;
`else
    assign bus.waw_err = 1'b0;
`endif
endmodule
